// File: rtl/end_screen_renderer_if.sv
// Pixel/ROM/control bundle between the end-screen renderer and its surroundings.
// The slave side is the renderer; the master side drives scan position, control and ROM data.
interface end_screen_renderer_if #(
  parameter int ADDR_W = 14,
  parameter int SEL_W  = 1
);
  logic              show;
  logic [SEL_W-1:0]  screen_sel;
  logic              frame_start;
  logic [9:0]        x;
  logic [8:0]        y;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic              active;
  logic              done;

  modport master (
    output show, screen_sel, frame_start, x, y, rom_q,
    input  rom_addr, r, g, b, active, done
  );

  modport slave (
    input  show, screen_sel, frame_start, x, y, rom_q,
    output rom_addr, r, g, b, active, done
  );
endinterface

// File: rtl/end_screen_renderer.sv
// End-screen sprite renderer: scan position -> ROM address -> tinted, faded pixel (3-cycle latency).
// A frame-rate fade FSM ramps the brightness level in and out while show toggles.
module end_screen_renderer #(
  parameter int WIDTH       = 96,
  parameter int HEIGHT      = 72,
  parameter int NUM_SCREENS = 2,
  parameter int SCALE_LOG2  = 2,
  parameter int X0          = 128,
  parameter int Y0          = 96,
  parameter int FADE_BITS   = 4,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = $clog2(NUM_SCREENS * WIDTH * HEIGHT),
  parameter int SEL_W       = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1
) (
  input  logic clk,
  input  logic reset,
  end_screen_renderer_if.slave bus
);

  localparam int LVL_W = FADE_BITS + 1;
  localparam logic [LVL_W-1:0] FADE_MAX = LVL_W'(2 ** FADE_BITS);
  localparam logic [LVL_W-1:0] LVL_ZERO = '0;

  localparam logic [31:0] X_LO      = 32'(X0);
  localparam logic [31:0] X_HI      = 32'(X0 + (WIDTH << SCALE_LOG2));
  localparam logic [31:0] Y_LO      = 32'(Y0);
  localparam logic [31:0] Y_HI      = 32'(Y0 + (HEIGHT << SCALE_LOG2));
  localparam logic [31:0] SPR_W     = 32'(WIDTH);
  localparam logic [31:0] SCR_WORDS = 32'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} state_t;

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               done_c;

  logic [31:0]        xw, yw, col, row;
  logic               in_win;
  logic [ADDR_W-1:0]  addr_c;
  logic [ADDR_W-1:0]  rom_addr_p1;
  logic               vld_p1, vld_p2;
  logic [DATA_W-1:0]  lum;
  logic [DATA_W-1:0]  r_p3, g_p3, b_p3;
  logic               vld_p3;

  // Brightness scaling: full level passes rom_q through unchanged.
  function automatic logic [DATA_W-1:0] fade_scale(input logic [DATA_W-1:0] q,
                                                   input logic [LVL_W-1:0]  lvl);
    logic [DATA_W+LVL_W-1:0] prod;
    logic [DATA_W+LVL_W-1:0] sh;
    prod = {{LVL_W{1'b0}}, q} * {{DATA_W{1'b0}}, lvl};
    sh   = prod >> FADE_BITS;
    if (|sh[DATA_W+LVL_W-1:DATA_W]) return '1;
    return sh[DATA_W-1:0];
  endfunction

  function automatic logic [LVL_W-1:0] lvl_inc(input logic [LVL_W-1:0] l);
    return (l >= FADE_MAX) ? FADE_MAX : l + LVL_W'(1);
  endfunction

  function automatic logic [LVL_W-1:0] lvl_dec(input logic [LVL_W-1:0] l);
    return (l == LVL_ZERO) ? LVL_ZERO : l - LVL_W'(1);
  endfunction

  // Fade FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      level_q <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      sel_q   <= sel_d;
    end
  end

  // Level steps in the current state's direction even when show flips in the same cycle.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        level_d = '0;
        if (bus.show) begin
          state_d = FADE_IN;
          sel_d   = bus.screen_sel;
        end
      end
      FADE_IN: begin
        if (bus.frame_start) level_d = lvl_inc(level_q);
        if (!bus.show)                state_d = FADE_OUT;
        else if (level_d == FADE_MAX) state_d = HOLD;
      end
      HOLD: begin
        level_d = FADE_MAX;
        if (!bus.show) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (bus.frame_start) level_d = lvl_dec(level_q);
        if (bus.show)                 state_d = FADE_IN;
        else if (level_d == LVL_ZERO) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        level_d = '0;
      end
    endcase
  end

  always_comb begin
    done_c = (state_q == HOLD);
  end

  // C1: window test and sprite address; offsets stay zero outside the window.
  always_comb begin
    xw     = 32'(bus.x);
    yw     = 32'(bus.y);
    in_win = (xw >= X_LO) && (xw < X_HI) && (yw >= Y_LO) && (yw < Y_HI);
    col    = in_win ? ((xw - X_LO) >> SCALE_LOG2) : 32'd0;
    row    = in_win ? ((yw - Y_LO) >> SCALE_LOG2) : 32'd0;
    addr_c = ADDR_W'(32'(sel_q) * SCR_WORDS + row * SPR_W + col);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rom_addr_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      if (in_win) rom_addr_p1 <= addr_c;
      vld_p1 <= in_win;
    end
  end

  // C2: external ROM registers its data; only the valid is carried here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p2 <= 1'b0;
    else        vld_p2 <= vld_p1;
  end

  // C3: fade, tint and blanking.
  always_comb begin
    lum = fade_scale(bus.rom_q, level_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p3   <= '0;
      g_p3   <= '0;
      b_p3   <= '0;
      vld_p3 <= 1'b0;
    end else if (!vld_p2 || level_q == LVL_ZERO) begin
      r_p3   <= '0;
      g_p3   <= '0;
      b_p3   <= '0;
      vld_p3 <= 1'b0;
    end else begin
      vld_p3 <= 1'b1;
      r_p3   <= lum;
      if (sel_q == SEL_W'(0)) begin
        g_p3 <= lum;
        b_p3 <= lum >> 2;
      end else if (sel_q == SEL_W'(1)) begin
        g_p3 <= '0;
        b_p3 <= '0;
      end else begin
        g_p3 <= lum;
        b_p3 <= lum;
      end
    end
  end

  assign bus.rom_addr = rom_addr_p1;
  assign bus.r        = r_p3;
  assign bus.g        = g_p3;
  assign bus.b        = b_p3;
  assign bus.active   = vld_p3;
  assign bus.done     = done_c;

endmodule

// File: tb/tb_end_screen_renderer.sv
// Self-checking bench for end_screen_renderer: ROM model, pixel scoreboard and fade sequences.
module tb_end_screen_renderer;

  localparam int ADDR_W = 14;
  localparam int WORDS  = 2 * 96 * 72;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  end_screen_renderer_if #(.ADDR_W(ADDR_W), .SEL_W(1)) bus ();

  end_screen_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [WORDS];
  always @(posedge clk) bus.rom_q <= mem[bus.rom_addr];

  typedef struct {int x; int y; bit in_w; int off;} vec_t;
  typedef struct {int due; bit act; int r; int g; int b;} pix_t;
  typedef struct {int due; int addr;} addr_t;

  vec_t  vecs[11];
  pix_t  pix_q[$];
  addr_t addr_q[$];
  int    exp_level = 0;
  int    exp_sel = 0;

  task automatic check(input string nm, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d", nm, act, act, expv, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
      check("rom_addr", int'(bus.rom_addr), addr_q[0].addr);
      addr_q.delete(0);
    end
    if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
      check("active", int'(bus.active), int'(pix_q[0].act));
      check("r", int'(bus.r), pix_q[0].r);
      check("g", int'(bus.g), pix_q[0].g);
      check("b", int'(bus.b), pix_q[0].b);
      pix_q.delete(0);
    end
  end

  // Drive one pixel and queue its expected address (C1) and colour (C3).
  task automatic pix(input int px, input int py, input bit in_w, input int off);
    pix_t  p;
    addr_t a;
    int    lum;
    @(negedge clk);
    bus.x = 10'(px);
    bus.y = 9'(py);
    a.due  = cyc + 1;
    a.addr = exp_sel * 6912 + off;
    if (in_w) addr_q.push_back(a);
    p.due = cyc + 3;
    p.act = 1'b0; p.r = 0; p.g = 0; p.b = 0;
    if (in_w && exp_level != 0) begin
      lum = (int'(mem[a.addr]) * exp_level) / 16;
      p.act = 1'b1;
      p.r = lum;
      p.g = (exp_sel == 1) ? 0 : lum;
      p.b = (exp_sel == 1) ? 0 : lum / 4;
    end
    pix_q.push_back(p);
  endtask

  task automatic settle();
    @(negedge clk);
    bus.x = 10'd0;
    bus.y = 9'd0;
    repeat (5) @(negedge clk);
  endtask

  task automatic frame();
    @(negedge clk);
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic run_table();
    for (int i = 0; i < 11; i++) pix(vecs[i].x, vecs[i].y, vecs[i].in_w, vecs[i].off);
    settle();
  endtask

  initial begin
    vecs[0]  = '{128, 96, 1'b1, 0};
    vecs[1]  = '{131, 100, 1'b1, 96};
    vecs[2]  = '{132, 100, 1'b1, 97};
    vecs[3]  = '{127, 100, 1'b0, 0};
    vecs[4]  = '{512, 100, 1'b0, 0};
    vecs[5]  = '{511, 383, 1'b1, 6911};
    vecs[6]  = '{200, 384, 1'b0, 0};
    vecs[7]  = '{200, 95, 1'b0, 0};
    vecs[8]  = '{639, 479, 1'b0, 0};
    vecs[9]  = '{256, 200, 1'b1, 2528};
    vecs[10] = '{300, 150, 1'b1, 1291};
    for (int i = 0; i < WORDS; i++) mem[i] = 8'((i * 37 + 11) & 255);
    mem[0]    = 8'hC8;
    mem[6912] = 8'hFF;

    reset = 1'b0;
    bus.show = 1'b0; bus.screen_sel = 1'b0; bus.frame_start = 1'b0;
    bus.x = 10'd0; bus.y = 9'd0;
    repeat (3) @(negedge clk);
    check("reset_r", int'(bus.r), 0);
    check("reset_active", int'(bus.active), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_rom_addr", int'(bus.rom_addr), 0);
    reset = 1'b1;

    // Fade in to the win screen one frame at a time.
    @(negedge clk);
    bus.show = 1'b1; bus.screen_sel = 1'b0; exp_sel = 0;
    for (int k = 1; k <= 16; k++) begin
      frame();
      exp_level = k;
      check($sformatf("done_after_frame%0d", k), int'(bus.done), (k == 16) ? 1 : 0);
      pix(128, 96, 1'b1, 0);
      settle();
    end

    run_table();
    pix(128, 96, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("hold_win_r", int'(bus.r), 8'hC8);
    check("hold_win_g", int'(bus.g), 8'hC8);
    check("hold_win_b", int'(bus.b), 8'h32);
    settle();
    frame(); frame();
    check("hold_sat_done", int'(bus.done), 1);
    pix(128, 96, 1'b1, 0);
    settle();

    // Fade out, then come back on the lose screen at half level.
    bus.show = 1'b0;
    for (int k = 15; k >= 0; k--) begin
      frame();
      exp_level = k;
    end
    check("idle_done", int'(bus.done), 0);
    pix(128, 96, 1'b1, 0);
    settle();
    bus.show = 1'b1; bus.screen_sel = 1'b1; exp_sel = 1;
    for (int k = 1; k <= 8; k++) begin
      frame();
      exp_level = k;
    end
    run_table();
    pix(128, 96, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("lose_half_r", int'(bus.r), 8'h7F);
    check("lose_half_g", int'(bus.g), 0);
    check("lose_half_b", int'(bus.b), 0);
    settle();
    bus.show = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      frame();
      exp_level = k;
    end
    pix(131, 100, 1'b1, 96);
    settle();
    check("faded_done", int'(bus.done), 0);

    // Reverse mid fade-out: win tint kept although lose is now selected.
    bus.screen_sel = 1'b0;
    @(negedge clk);
    bus.show = 1'b1; exp_sel = 0;
    for (int k = 1; k <= 7; k++) begin
      frame();
      exp_level = k;
    end
    @(negedge clk);
    bus.show = 1'b0;
    frame(); frame();
    exp_level = 5;
    pix(128, 96, 1'b1, 0);
    settle();
    bus.screen_sel = 1'b1;
    bus.show = 1'b1;
    @(negedge clk);
    pix(128, 96, 1'b1, 0);
    repeat (3) @(negedge clk);
    check("reverse_b_yellow", int'(bus.b), 8'h0F);
    settle();

    // show drop in the same cycle as frame_start: still steps up once.
    @(negedge clk);
    bus.show = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
    exp_level = 6;
    pix(128, 96, 1'b1, 0);
    settle();
    frame();
    exp_level = 5;
    pix(128, 96, 1'b1, 0);
    settle();

    bus.show = 1'b1;
    for (int k = 6; k <= 16; k++) begin
      frame();
      exp_level = k;
    end
    check("rehold_done", int'(bus.done), 1);

    // Asynchronous reset mid-HOLD while an in-window pixel streams.
    @(negedge clk);
    bus.x = 10'd128; bus.y = 9'd96;
    repeat (4) @(negedge clk);
    check("prereset_active", int'(bus.active), 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_r", int'(bus.r), 0);
    check("async_g", int'(bus.g), 0);
    check("async_b", int'(bus.b), 0);
    check("async_active", int'(bus.active), 0);
    check("async_done", int'(bus.done), 0);
    @(negedge clk);
    bus.show = 1'b0;
    reset = 1'b1;
    exp_level = 0;
    pix(128, 96, 1'b1, 0);
    settle();

    check("scoreboard_drained", pix_q.size() + addr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
